// File: rtl/rr_arb_mux_if.sv
// Handshake bundle for rr_arb_mux: N valid/ready input channels and one registered
// output. The arbiter connects through the slave modport; the producer/consumer side uses master.
interface rr_arb_mux_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_sel;
  logic               out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_arb_mux.sv
// N-input round-robin arbitrating multiplexer with a single registered output stage.
// The granted channel's beat is captured into the output register, and priority rotates past it.
module rr_arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input  logic         clk,
  input  logic         rst,
  rr_arb_mux_if.slave  bus
);
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;
  localparam int SUM_W = SEL_W + 1;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N - 1);

  logic [SEL_W-1:0] ptr_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic [SEL_W-1:0] out_sel_r;
  logic             block_r;

  logic [N-1:0]     grant_s;
  logic [SEL_W-1:0] grant_idx_s;
  logic             grant_any_s;
  logic [SUM_W-1:0] cand_sum_s;
  logic [SEL_W-1:0] cand_idx_s;
  logic [WIDTH-1:0] grant_data_s;
  logic [SEL_W-1:0] ptr_next_s;
  logic             load_s;
  logic             take_s;

  // Rotating priority search starting at ptr_r, wrapping modulo N.
  always_comb begin
    grant_s     = '0;
    grant_idx_s = '0;
    grant_any_s = 1'b0;
    cand_sum_s  = '0;
    cand_idx_s  = '0;
    for (int k = 0; k < N; k++) begin
      cand_sum_s = {1'b0, ptr_r} + SUM_W'(k);
      if (cand_sum_s >= SUM_W'(N)) begin
        cand_sum_s = cand_sum_s - SUM_W'(N);
      end else begin
        cand_sum_s = cand_sum_s;
      end
      cand_idx_s = cand_sum_s[SEL_W-1:0];
      if (!grant_any_s && bus.in_valid[cand_idx_s]) begin
        grant_any_s = 1'b1;
        grant_idx_s = cand_idx_s;
      end else begin
        grant_any_s = grant_any_s;
      end
    end
    grant_s[grant_idx_s] = grant_any_s;
  end

  // AND-OR payload select; grant_s is one-hot or zero.
  always_comb begin
    grant_data_s = '0;
    for (int i = 0; i < N; i++) begin
      grant_data_s = grant_data_s | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
    end
  end

  assign load_s     = !out_valid_r || bus.out_ready;
  // block_r keeps the arbiter closed for the first edge after reset release.
  assign take_s     = load_s && grant_any_s && !block_r;
  assign ptr_next_s = (grant_idx_s == LAST_IDX) ? '0 : grant_idx_s + SEL_W'(1);

  assign bus.in_ready  = take_s ? grant_s : '0;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_sel   = out_sel_r;

  // Post-reset acceptance block, set asynchronously with rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      block_r <= 1'b1;
    end else begin
      block_r <= 1'b0;
    end
  end

  // Output register and priority pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sel_r   <= '0;
      ptr_r       <= '0;
    end else if (take_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= grant_data_s;
      out_sel_r   <= grant_idx_s;
      ptr_r       <= ptr_next_s;
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end
endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

Parametrised N-input round-robin arbitrating multiplexer with a valid/ready handshake on every port and one registered output stage. It generalises the fixed 2/3/4-way 32-bit selectors: the select is generated internally by a fair arbiter, not driven by control logic. It sits wherever several producers share one consumer, such as multiple bus masters feeding the data-memory port or several writeback sources feeding a shared queue.

## Interface
- WIDTH, 32: payload width in bits.
- N, 4: number of input channels, 1..16.
- SEL_W, derived as max(1, clog2(N)): width of the channel index. Not overridden by instantiators.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  N  bit i means channel i presents data.
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  N  bit i means channel i's beat is accepted this cycle.
- out_valid  out  1  output register holds a beat.
- out_data  out  WIDTH  registered payload.
- out_sel  out  SEL_W  index of the channel that supplied out_data.
- out_ready  in  1  consumer accepts the beat.

## Operation
- State:
  - output register: out_valid, out_data, out_sel.
  - priority pointer ptr, SEL_W bits, range 0..N-1.
- Load enable: load = !out_valid || out_ready.
- Arbitration (combinational):
  - Search channels ptr, ptr+1, …, N-1, 0, …, ptr-1, wrapping modulo N, not modulo 2^SEL_W.
  - The first channel with in_valid set is granted.
  - grant is one-hot, or all-zero when no in_valid is set.
- in_ready[i] = load && grant[i]. At most one bit of in_ready is high in any cycle.
- Transfer in: in_valid[i] && in_ready[i]. On the next edge:
  - out_data <= channel i data;
  - out_sel <= i;
  - out_valid <= 1;
  - ptr <= (i+1) mod N.
- Transfer out: out_valid && out_ready.
  - If the same cycle has no transfer in, out_valid <= 0.
  - out_data and out_sel keep their old values.
- Simultaneous transfer out and transfer in: the register is overwritten with the new beat and out_valid stays 1. Full throughput is one beat per cycle.
- Backpressure: when out_valid && !out_ready, load = 0 and all in_ready are 0. out_data, out_sel and ptr hold.
- ptr changes only on a transfer in. Idle cycles and stalls do not move it.
- N=1: ptr and out_sel are constant 0. The block degenerates to a single pipeline register with handshake.
- Inputs are required to follow AXI-style rules: once asserted, in_valid[i] and in_data[i] hold until accepted. The block does not check this.

## Timing
- Reset values, applied immediately on rst assertion, independent of clk:
  - out_valid = 0;
  - out_data = 0;
  - out_sel = 0;
  - ptr = 0, so channel 0 has highest priority after reset.
- While rst is high, in_ready = 0.
- Reset mid-transfer: a beat in the output register is discarded. No beat is accepted in the cycle in which rst deasserts asynchronously before the edge.
- Latency: a beat accepted at edge k appears on out_valid/out_data after edge k, i.e. one cycle.
- Combinational paths:
  - in_valid and out_ready to in_ready: permitted.
  - in_data to any output: not permitted.
  - anything to out_valid/out_data/out_sel: not permitted; these are register outputs.
- Fairness: with all N channels continuously valid and out_ready=1, each channel is granted exactly once every N cycles.

## Test plan
- Reset: assert rst mid-cycle with out_valid=1 -> out_valid, out_data, out_sel drop to 0 at once; in_ready=0 while rst is high.
- Single requester, N=4, WIDTH=32: channel 2 presents 0xDEADBEEF, out_ready=1 -> in_ready=0100 for one cycle; next cycle out_valid=1, out_data=0xDEADBEEF, out_sel=2; then ptr=3.
- Round robin: all four channels valid continuously, out_ready=1 -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles, with no bubbles.
- Pointer skip: after a grant to channel 2, only channels 1 and 3 are valid -> channel 3 granted first, then channel 1.
- Backpressure: hold out_ready=0 for 5 cycles with out_valid=1 and channel 1 valid -> out_data and out_sel stable; in_ready=0000; ptr unchanged. Raise out_ready -> channel 1 accepted in that same cycle.
- Wrap and N=3: ptr=2, channels 0 and 2 valid -> channel 2 granted, ptr wraps to 0 (not 3), then channel 0 granted.
